// File: rtl/rotary_debounce.sv
// -----------------------------------------------------------------------------
// rotary_debounce
//
// Front end for a quadrature rotary encoder with an integrated push button.
// The three raw pins are each brought into the clock domain through a two-flop
// synchronizer. Each synchronized level is then filtered by its own counter.
// A debounced level only follows a new input level after that level has held
// for a full stable window. The button is active-low on the pin. It is
// inverted before filtering, so btn_o reads 1 while the button is pressed.
// Single-cycle press/release strobes accompany each debounced button change.
//
// No quadrature legality is enforced here. Direction decoding is the job of
// the downstream rotary_decoder.
//
// Parameters
//   ROT_STABLE_CYCLES  stable window, in clocks, for each rotary channel (>= 1)
//   BTN_STABLE_CYCLES  stable window, in clocks, for the push button     (>= 1)
//
// Ports
//   CLK_i          system clock; all logic runs on the rising edge
//   RST_i          synchronous, active-high reset
//   D14_i          raw rotary channel A (pulled up, idle high)
//   D15_i          raw rotary channel B (pulled up, idle high)
//   B16_i          raw push button, active-low
//   rot_1_o        debounced channel A level
//   rot_2_o        debounced channel B level
//   btn_o          debounced button level, active-high (1 = pressed)
//   btn_press_o    one-cycle strobe, coincident with btn_o first reading 1
//   btn_release_o  one-cycle strobe, coincident with btn_o first reading 0
// -----------------------------------------------------------------------------
module rotary_debounce #(
    parameter int ROT_STABLE_CYCLES = 250,
    parameter int BTN_STABLE_CYCLES = 12000
) (
    input  logic CLK_i,
    input  logic RST_i,
    input  logic D14_i,
    input  logic D15_i,
    input  logic B16_i,
    output logic rot_1_o,
    output logic rot_2_o,
    output logic btn_o,
    output logic btn_press_o,
    output logic btn_release_o
);

    // Each counter can hold its channel's parameter value. The count itself
    // never goes above N-1 and never wraps.
    localparam int ROT_CNT_W = $clog2(ROT_STABLE_CYCLES + 1);
    localparam int BTN_CNT_W = $clog2(BTN_STABLE_CYCLES + 1);

    localparam logic [ROT_CNT_W-1:0] ROT_LAST = ROT_CNT_W'(ROT_STABLE_CYCLES - 1);
    localparam logic [BTN_CNT_W-1:0] BTN_LAST = BTN_CNT_W'(BTN_STABLE_CYCLES - 1);
    localparam logic [ROT_CNT_W-1:0] ROT_ONE  = ROT_CNT_W'(1);
    localparam logic [BTN_CNT_W-1:0] BTN_ONE  = BTN_CNT_W'(1);

    // -------------------------------------------------------------------------
    // Synchronizers. Bit 0 = channel A, bit 1 = channel B, bit 2 = button pin.
    // All pins idle high, so every flop resets to 1. A button held down
    // through reset therefore looks like a fresh press once reset releases.
    // -------------------------------------------------------------------------
    logic [2:0] raw;
    logic [2:0] sync1;
    logic [2:0] sync2;

    assign raw = {B16_i, D15_i, D14_i};

    // NOTE: clocked state uses non-blocking assignments, so every flop samples
    // the pre-edge value of every other flop, whatever the statement order.
    always_ff @(posedge CLK_i) begin
        if (RST_i) begin
            sync1 <= 3'b111;
            sync2 <= 3'b111;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    // Only the second synchronizer stage feeds the filters. The button is
    // inverted here so the rest of the button path is active-high.
    logic rot_1_sample;
    logic rot_2_sample;
    logic btn_sample;

    assign rot_1_sample = sync2[0];
    assign rot_2_sample = sync2[1];
    assign btn_sample   = ~sync2[2];

    // -------------------------------------------------------------------------
    // Rotary channel A filter
    // -------------------------------------------------------------------------
    logic [ROT_CNT_W-1:0] rot_1_cnt;
    logic [ROT_CNT_W-1:0] rot_1_cnt_next;
    logic                 rot_1_next;

    // NOTE: every combinational output gets a default before any branch, so no
    // path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        rot_1_cnt_next = '0;
        rot_1_next     = rot_1_o;
        if (rot_1_sample != rot_1_o) begin
            // The mismatch has lasted N cycles once the count reaches N-1.
            // The level then flips and the counter falls back to its default 0.
            if (rot_1_cnt == ROT_LAST) begin
                rot_1_next = rot_1_sample;
            end else begin
                rot_1_cnt_next = rot_1_cnt + ROT_ONE;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Rotary channel B filter
    // -------------------------------------------------------------------------
    logic [ROT_CNT_W-1:0] rot_2_cnt;
    logic [ROT_CNT_W-1:0] rot_2_cnt_next;
    logic                 rot_2_next;

    always_comb begin
        rot_2_cnt_next = '0;
        rot_2_next     = rot_2_o;
        if (rot_2_sample != rot_2_o) begin
            if (rot_2_cnt == ROT_LAST) begin
                rot_2_next = rot_2_sample;
            end else begin
                rot_2_cnt_next = rot_2_cnt + ROT_ONE;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Button filter and edge strobes
    // -------------------------------------------------------------------------
    logic [BTN_CNT_W-1:0] btn_cnt;
    logic [BTN_CNT_W-1:0] btn_cnt_next;
    logic                 btn_next;
    logic                 btn_update;
    logic                 press_next;
    logic                 release_next;

    always_comb begin
        btn_cnt_next = '0;
        btn_next     = btn_o;
        btn_update   = 1'b0;
        if (btn_sample != btn_o) begin
            if (btn_cnt == BTN_LAST) begin
                btn_next   = btn_sample;
                btn_update = 1'b1;
            end else begin
                btn_cnt_next = btn_cnt + BTN_ONE;
            end
        end
        // The strobes are registered on the same edge as btn_o. Each one is
        // therefore high for exactly the first cycle of the new level. A single
        // update has one direction only, so the two strobes are mutually
        // exclusive.
        press_next   = btn_update &  btn_sample;
        release_next = btn_update & ~btn_sample;
    end

    // -------------------------------------------------------------------------
    // Filter state registers. Reset discards any partial counts. It also
    // forces the idle levels, and it never raises a strobe.
    // -------------------------------------------------------------------------
    always_ff @(posedge CLK_i) begin
        if (RST_i) begin
            rot_1_cnt     <= '0;
            rot_2_cnt     <= '0;
            btn_cnt       <= '0;
            rot_1_o       <= 1'b1;
            rot_2_o       <= 1'b1;
            btn_o         <= 1'b0;
            btn_press_o   <= 1'b0;
            btn_release_o <= 1'b0;
        end else begin
            rot_1_cnt     <= rot_1_cnt_next;
            rot_2_cnt     <= rot_2_cnt_next;
            btn_cnt       <= btn_cnt_next;
            rot_1_o       <= rot_1_next;
            rot_2_o       <= rot_2_next;
            btn_o         <= btn_next;
            btn_press_o   <= press_next;
            btn_release_o <= release_next;
        end
    end

endmodule

// File: tb/tb_rotary_debounce.sv
// -----------------------------------------------------------------------------
// tb_rotary_debounce
//
// Directed bench for rotary_debounce, with ROT_STABLE_CYCLES = 4 and
// BTN_STABLE_CYCLES = 6. Each stimulus step drives the pins for one edge. It
// queues the output vector expected after that edge, tagged with the edge
// number. A separate monitor checks the DUT on each falling edge against the
// queue entries due for that edge.
//
// Inside each scenario, loop index j = 0 is the edge that first samples the
// new pin level into sync1. For a window of N, an output changes after edge
// j = N + 1: 5 for the rotary channels and 7 for the button.
//
// Vector bit order: {rot_1, rot_2, btn, btn_press, btn_release}.
// -----------------------------------------------------------------------------
module tb_rotary_debounce;

    logic clk;
    logic rst;
    logic d14;
    logic d15;
    logic b16;
    logic rot_1;
    logic rot_2;
    logic btn;
    logic btn_press;
    logic btn_release;

    rotary_debounce #(
        .ROT_STABLE_CYCLES(4),
        .BTN_STABLE_CYCLES(6)
    ) dut (
        .CLK_i        (clk),
        .RST_i        (rst),
        .D14_i        (d14),
        .D15_i        (d15),
        .B16_i        (b16),
        .rot_1_o      (rot_1),
        .rot_2_o      (rot_2),
        .btn_o        (btn),
        .btn_press_o  (btn_press),
        .btn_release_o(btn_release)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edge counter: holds the number of the most recent rising edge.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        logic [4:0] exp;
        string      name;
    } sb_item_t;

    sb_item_t sb[$];

    int n_vec = 0;
    int n_err = 0;

    function automatic logic [4:0] v(input logic r1, input logic r2, input logic b,
                                     input logic p, input logic rl);
        return {r1, r2, b, p, rl};
    endfunction

    // Drive the pins for the next edge and queue the vector expected after it.
    task automatic apply(input logic a, input logic b, input logic bt, input logic r,
                         input logic [4:0] exp, input string name);
        sb_item_t it;
        d14 = a;
        d15 = b;
        b16 = bt;
        rst = r;
        it.cyc  = cyc + 1;
        it.exp  = exp;
        it.name = name;
        sb.push_back(it);
        @(posedge clk);
        #2;
    endtask

    // Monitor: compares the DUT outputs half a cycle after each rising edge.
    always @(negedge clk) begin
        logic [4:0] act;
        sb_item_t   it;
        act = {rot_1, rot_2, btn, btn_press, btn_release};
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            it = sb.pop_front();
            n_vec++;
            if (it.cyc != cyc || act !== it.exp) begin
                n_err++;
                $display("FAIL %s edge %0d (due %0d): got %b, expected %b",
                         it.name, cyc, it.cyc, act, it.exp);
            end
        end
    end

    initial begin
        d14 = 1'b1;
        d15 = 1'b1;
        b16 = 1'b1;
        rst = 1'b1;
        @(posedge clk);
        #2;

        // Reset state, then idle.
        for (int j = 0; j < 3; j++) apply(1, 1, 1, 1, v(1, 1, 0, 0, 0), "reset_state");
        for (int j = 0; j < 3; j++) apply(1, 1, 1, 0, v(1, 1, 0, 0, 0), "idle_after_reset");

        // Clean fall and rise on channel A. Channel B and the button stay put.
        for (int j = 0; j < 8; j++) apply(0, 1, 1, 0, v(j < 5, 1, 0, 0, 0), "clean_fall_a");
        for (int j = 0; j < 8; j++) apply(1, 1, 1, 0, v(j >= 5, 1, 0, 0, 0), "clean_rise_a");

        // Bounce on channel B: low 3, high 1, then low. The final low is
        // sampled at j = 4, so rot_2 falls after edge 9 and not before.
        for (int j = 0; j < 13; j++) apply(1, (j == 3), 1, 0, v(1, j < 9, 0, 0, 0), "bounce_b");
        for (int j = 0; j < 8; j++) apply(1, 1, 1, 0, v(1, j >= 5, 0, 0, 0), "bounce_b_rise");

        // Button press held for 20 cycles, then release.
        for (int j = 0; j < 20; j++) apply(1, 1, 0, 0, v(1, 1, j >= 7, j == 7, 0), "btn_press");
        for (int j = 0; j < 12; j++) apply(1, 1, 1, 0, v(1, 1, j < 7, 0, j == 7), "btn_release");

        // 3-cycle glitch on the button: no level change and no strobe.
        for (int j = 0; j < 13; j++) apply(1, 1, (j >= 3), 0, v(1, 1, 0, 0, 0), "btn_glitch");

        // Reset while channel A is mid-count. j = 4 is the first post-reset
        // sample edge, so rot_1 falls after edge 9.
        for (int j = 0; j < 14; j++) apply(0, 1, 1, (j == 3), v(j < 9, 1, 0, 0, 0), "rst_mid_count");
        for (int j = 0; j < 8; j++) apply(1, 1, 1, 0, v(j >= 5, 1, 0, 0, 0), "rst_mid_rise");

        // Button held low through a 2-cycle reset. The first post-reset sample
        // edge is j = 2, so btn rises and press strobes after edge 9.
        for (int j = 0; j < 15; j++) apply(1, 1, 0, (j < 2), v(1, 1, j >= 9, j == 9, 0), "rst_btn_held");
        for (int j = 0; j < 10; j++) apply(1, 1, 1, 0, v(1, 1, j < 7, 0, j == 7), "rst_btn_release");

        // Independent channels: A falls at j = 0, B two cycles later.
        for (int j = 0; j < 12; j++) apply(0, (j < 2), 1, 0, v(j < 5, j < 7, 0, 0, 0), "indep_fall");
        for (int j = 0; j < 10; j++) apply(1, 1, 1, 0, v(j >= 5, j >= 5, 0, 0, 0), "indep_rise");

        // Let the monitor drain the last entries, then confirm nothing was left.
        repeat (3) @(posedge clk);
        #2;
        n_vec++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: got %0d pending entries, expected 0", sb.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/rotary_debounce.md
ROTARY_DEBOUNCE -- requirements
Module: rotary_debounce

Interface
REQ-001 Parameter ROT_STABLE_CYCLES, default 250: consecutive clock cycles a synchronized rotary input must hold a new level before its output changes.
REQ-002 Parameter BTN_STABLE_CYCLES, default 12000: the same count for the push button (1 ms at 12 MHz).
REQ-003 Both parameters SHALL be integers >= 1; each channel's internal counter SHALL be sized with $clog2 to hold the channel's parameter value without overflow.
REQ-004 CLK_i  input  1  single system clock; all logic on its rising edge.
REQ-005 RST_i  input  1  synchronous, active-high reset.
REQ-006 D14_i  input  1  raw asynchronous rotary channel A (pulled up, idle high).
REQ-007 D15_i  input  1  raw asynchronous rotary channel B (pulled up, idle high).
REQ-008 B16_i  input  1  raw asynchronous push button, active-low (low = pressed).
REQ-009 rot_1_o  output  1  debounced channel A level, for rotary_decoder rot_1_i.
REQ-010 rot_2_o  output  1  debounced channel B level, for rotary_decoder rot_2_i.
REQ-011 btn_o  output  1  debounced button state, active-high (1 = pressed).
REQ-012 btn_press_o  output  1  one-cycle pulse on a debounced press.
REQ-013 btn_release_o  output  1  one-cycle pulse on a debounced release.

Function
REQ-014 Each raw input SHALL pass through a two-flop synchronizer (sync1, sync2); only sync2 feeds the debounce logic.
REQ-015 The button channel SHALL invert sync2 before debounce, so the debounced button level is active-high.
REQ-016 Each of the three channels SHALL have an independent counter and a registered debounced level (the output).
REQ-017 Counter rule, when sync2 equals the debounced level: the counter SHALL clear to 0.
REQ-018 Counter rule, when sync2 differs and counter < N-1 (N = the channel's parameter): the counter SHALL increment by 1.
REQ-019 Counter rule, when sync2 differs and counter = N-1: on that edge the debounced level SHALL take the sync2 value and the counter SHALL clear to 0.
REQ-020 Latency: after a raw input changes and holds, the output SHALL update on exactly the (N+1)th rising edge after the edge that first captures the new level into sync1.
REQ-021 Any mismatch run shorter than N cycles (bounce or glitch) SHALL produce no output change, and the counter SHALL restart from 0 on the next mismatch.
REQ-022 btn_press_o SHALL be registered and asserted for exactly the one cycle in which btn_o first reads 1 after a 0→1 update.
REQ-023 btn_release_o SHALL behave the same way for a 1→0 update of btn_o.
REQ-024 btn_press_o and btn_release_o SHALL never assert in the same cycle.
REQ-025 Channels SHALL be fully independent: simultaneous transitions on D14_i and D15_i SHALL each debounce with their own timing.
REQ-026 The block SHALL NOT enforce quadrature legality; direction decoding belongs to rotary_decoder.
REQ-027 The counters SHALL never wrap; the maximum count reached is N-1.

Reset
REQ-028 While RST_i is high at a rising edge, the following SHALL load the stated values:
- all sync flops: 1 (inputs idle high);
- all counters: 0;
- rot_1_o = 1, rot_2_o = 1;
- btn_o = 0;
- btn_press_o = 0, btn_release_o = 0.
REQ-029 Reset asserted mid-debounce SHALL discard partial counts.
REQ-030 Reset SHALL NOT generate a press or release pulse, including when B16_i is held low through and after reset; in that case btn_o rises N+1 edges after the edge that first samples B16_i low into sync1, with a normal btn_press_o pulse.
REQ-031 The first edge with RST_i low SHALL resume normal operation from the reset values.

Verification (sim with ROT_STABLE_CYCLES=4, BTN_STABLE_CYCLES=6)
REQ-032 Clean edge: D14_i 1→0 held, first sampled at edge k → rot_1_o = 0 from edge k+5; rot_2_o and btn_o unchanged.
REQ-033 Bounce: D15_i toggles low 3 cycles, high 1 cycle, low thereafter → rot_2_o stays 1 until 5 edges after the final low level is sampled; there is no intermediate change.
REQ-034 Button press/release: B16_i low for 20 cycles, then high → btn_o = 1 at sample edge +7, with btn_press_o = 1 for that single cycle only; after release, btn_o = 0 at release sample edge +7, with one btn_release_o cycle.
REQ-035 Glitch: a 3-cycle low pulse on B16_i → btn_o stays 0, and no pulse occurs on btn_press_o or btn_release_o.
REQ-036 Reset mid-count: D14_i low for 3 cycles, then RST_i for 1 cycle while D14_i stays low → rot_1_o = 1 after reset, then falls 5 edges after the first post-reset sample edge.
REQ-037 Reset with button held: B16_i low throughout a 2-cycle reset → btn_o = 0 and btn_press_o = 0 during reset; btn_o rises 7 edges after the first post-reset sample edge, with a single btn_press_o pulse.
